mem_arbiter: RTL

Parametrised N-channel request/acknowledge arbiter between the pipeline's memory requesters and the single backing memory port. It generalises the fixed two-port fetch/mem sharing to NCH channels and adds selectable fixed or round-robin priority, registered responses, and a downstream timeout that returns an error instead of hanging the pipeline. Requesters connect on the upstream side, and the backing memory connects on the downstream side.

---
 rtl/mem_pkg.sv | 31 +++
 rtl/mem_rr_pick.sv | 48 ++++
 rtl/mem_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared memory-subsystem definitions.
//               - Access width encodings used by the memory model, the mem
//                 stage and the arbiter.
//               - Arbiter state enum.
//               - Index wrap helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

   // Access width encodings carried on *_width fields
   localparam logic [1:0] MEM_B = 2'd0;
   localparam logic [1:0] MEM_H = 2'd1;
   localparam logic [1:0] MEM_W = 2'd2;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_t;

   // (base + ofs) mod n, assuming base < n and ofs < n. A single conditional
   // subtract keeps the circular search cheap for non-power-of-two n.
   function automatic int wrap_add(input int base, input int ofs, input int n);
      return ((base + ofs) >= n) ? (base + ofs - n) : (base + ofs);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : mem_rr_pick
// Description : Combinational winner selection for the memory arbiter.
//               - RR=1: first set request at or after ptr, with wrap.
//               - RR=0: lowest set request index.
// Ports       : req   in  NCH          - request vector
//               ptr   in  $clog2(NCH)  - round-robin start index
//               grant out $clog2(NCH)  - winning index (0 when none)
//               any   out 1            - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module mem_rr_pick
   import mem_pkg::*;
#(
   parameter int NCH = 2,
   parameter bit RR  = 1'b1
) (
   input  logic [NCH-1:0]         req,
   input  logic [$clog2(NCH)-1:0] ptr,
   output logic [$clog2(NCH)-1:0] grant,
   output logic                   any
);

   localparam int c_PW = $clog2(NCH);

   logic [c_PW-1:0] w_base;
   logic [c_PW-1:0] w_idx;

   // Fixed priority is round-robin anchored permanently at index 0.
   assign w_base = RR ? ptr : '0;
   assign any    = |req;

   // Scan offsets from farthest to nearest so the nearest set request
   // from the base is the last assignment and therefore wins.
   always_comb begin
      grant = '0;
      w_idx = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
         w_idx = c_PW'(wrap_add(int'(w_base), k, NCH));
         if (req[w_idx]) begin
            grant = w_idx;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : N-channel request/acknowledge arbiter in front of a single
//               backing memory port.
//               - Fixed or round-robin priority.
//               - Registered responses.
//               - Optional downstream timeout that completes the access
//                 with an error instead of hanging.
// Ports       : clk, reset_n            - clock, async active-low reset
//               ch_req/addr/write/...   - packed upstream requests
//               ch_ack/err/rdata        - registered one-hot completion
//               dn_req/addr/write/...   - registered downstream request
//               dn_ack/rdata            - downstream completion
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int NCH     = 2,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int RR      = 1,
   parameter int TIMEOUT = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NCH-1:0]    ch_req,
   input  logic [NCH*AW-1:0] ch_addr,
   input  logic [NCH-1:0]    ch_write,
   input  logic [NCH*DW-1:0] ch_wdata,
   input  logic [NCH-1:0]    ch_extend,
   input  logic [NCH*2-1:0]  ch_width,
   output logic [NCH-1:0]    ch_ack,
   output logic              ch_err,
   output logic [DW-1:0]     ch_rdata,
   output logic              dn_req,
   output logic [AW-1:0]     dn_addr,
   output logic              dn_write,
   output logic [DW-1:0]     dn_wdata,
   output logic              dn_extend,
   output logic [1:0]        dn_width,
   input  logic              dn_ack,
   input  logic [DW-1:0]     dn_rdata
);

   localparam int            c_PW      = $clog2(NCH);
   localparam int            c_CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam bit            c_TO_EN   = (TIMEOUT != 0);
   localparam logic [c_CW-1:0] c_TO_LAST = c_CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   arb_state_t       r_state;
   arb_state_t       w_next_state;

   logic [c_PW-1:0]  r_ptr;
   logic [c_PW-1:0]  r_gnt;
   logic [c_CW-1:0]  r_cnt;
   logic [NCH-1:0]   r_ack;
   logic             r_err;
   logic [DW-1:0]    r_rdata;
   logic             r_dn_req;
   logic [AW-1:0]    r_dn_addr;
   logic             r_dn_write;
   logic [DW-1:0]    r_dn_wdata;
   logic             r_dn_extend;
   logic [1:0]       r_dn_width;

   logic [c_PW-1:0]  w_grant;
   logic             w_any;
   logic             w_timeout;
   logic [AW-1:0]    w_sel_addr;
   logic             w_sel_write;
   logic [DW-1:0]    w_sel_wdata;
   logic             w_sel_extend;
   logic [1:0]       w_sel_width;

   mem_rr_pick #(
      .NCH (NCH),
      .RR  (RR != 0)
   ) u_pick (
      .req   (ch_req),
      .ptr   (r_ptr),
      .grant (w_grant),
      .any   (w_any)
   );

   // Timeout fires in the TIMEOUT-th BUSY cycle; dn_ack takes precedence.
   assign w_timeout = c_TO_EN && (r_cnt == c_TO_LAST);

   // Field mux for the winning channel
   always_comb begin
      w_sel_addr   = '0;
      w_sel_write  = 1'b0;
      w_sel_wdata  = '0;
      w_sel_extend = 1'b0;
      w_sel_width  = MEM_B;
      for (int i = 0; i < NCH; i++) begin
         if (w_grant == c_PW'(i)) begin
            w_sel_addr   = ch_addr[i*AW +: AW];
            w_sel_write  = ch_write[i];
            w_sel_wdata  = ch_wdata[i*DW +: DW];
            w_sel_extend = ch_extend[i];
            w_sel_width  = ch_width[i*2 +: 2];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ARB_IDLE: if (w_any) w_next_state = ARB_BUSY;
         ARB_BUSY: if (dn_ack || w_timeout) w_next_state = ARB_RESP;
         ARB_RESP: w_next_state = ARB_IDLE;
         default:  w_next_state = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr       <= '0;
         r_gnt       <= '0;
         r_cnt       <= '0;
         r_ack       <= '0;
         r_err       <= 1'b0;
         r_rdata     <= '0;
         r_dn_req    <= 1'b0;
         r_dn_addr   <= '0;
         r_dn_write  <= 1'b0;
         r_dn_wdata  <= '0;
         r_dn_extend <= 1'b0;
         r_dn_width  <= '0;
      end else begin
         // ch_ack is a single-cycle pulse; only the completing BUSY edge sets it.
         r_ack <= '0;
         case (r_state)
            ARB_IDLE: begin
               if (w_any) begin
                  r_gnt       <= w_grant;
                  r_ptr       <= (w_grant == c_PW'(NCH - 1)) ? '0 : c_PW'(w_grant + 1'b1);
                  r_cnt       <= '0;
                  r_dn_req    <= 1'b1;
                  r_dn_addr   <= w_sel_addr;
                  r_dn_write  <= w_sel_write;
                  r_dn_wdata  <= w_sel_wdata;
                  r_dn_extend <= w_sel_extend;
                  r_dn_width  <= w_sel_width;
               end
            end
            ARB_BUSY: begin
               if (r_cnt != '1) begin
                  r_cnt <= r_cnt + 1'b1;
               end
               if (dn_ack) begin
                  r_rdata  <= dn_rdata;
                  r_err    <= 1'b0;
                  r_dn_req <= 1'b0;
                  r_ack    <= NCH'(1) << r_gnt;
               end else if (w_timeout) begin
                  r_rdata  <= '0;
                  r_err    <= 1'b1;
                  r_dn_req <= 1'b0;
                  r_ack    <= NCH'(1) << r_gnt;
               end
            end
            default: ;
         endcase
      end
   end

   assign ch_ack    = r_ack;
   assign ch_err    = r_err;
   assign ch_rdata  = r_rdata;
   assign dn_req    = r_dn_req;
   assign dn_addr   = r_dn_addr;
   assign dn_write  = r_dn_write;
   assign dn_wdata  = r_dn_wdata;
   assign dn_extend = r_dn_extend;
   assign dn_width  = r_dn_width;

endmodule
`default_nettype wire
